// File: rtl/uart_apb_master_arb.sv
// Two-requester APB master in front of one UART APB slave port.
// Round-robin grant, SETUP/ACCESS sequencing and a bounded wait for pready.
module uart_apb_master_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                preset_n,
    input  logic                req0_valid,
    input  logic                req0_write,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [DATA_W-1:0]   req0_wdata,
    input  logic [DATA_W/8-1:0] req0_strb,
    output logic                req0_done,
    output logic                req0_err,
    output logic [DATA_W-1:0]   req0_rdata,
    input  logic                req1_valid,
    input  logic                req1_write,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req1_wdata,
    input  logic [DATA_W/8-1:0] req1_strb,
    output logic                req1_done,
    output logic                req1_err,
    output logic [DATA_W-1:0]   req1_rdata,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic                pready,
    input  logic                pslverr,
    input  logic [DATA_W-1:0]   prdata,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                tmo_hit_s;
    logic                xfer_done_s;
    logic                xfer_err_s;
    logic                arb_pick_s;

    // Timeout detection, completion and round-robin pick
    always_comb begin
        if ((TIMEOUT != 0) && (state_q == ST_ACCESS) && !pready && (cnt_q == TMO_LAST)) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
        xfer_done_s = (state_q == ST_ACCESS) && (pready || tmo_hit_s);
        xfer_err_s  = (pslverr & pready) | tmo_hit_s;
        if (req0_valid && req1_valid) begin
            arb_pick_s = ~last_grant_q;
        end else if (req1_valid) begin
            arb_pick_s = 1'b1;
        end else begin
            arb_pick_s = 1'b0;
        end
    end

    // Next-state logic; APB fields are captured from the winner only in IDLE
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_d      = ST_SETUP;
                    grant_d      = arb_pick_s;
                    last_grant_d = arb_pick_s;
                    psel_d       = 1'b1;
                    if (arb_pick_s) begin
                        pwrite_d = req1_write;
                        paddr_d  = req1_addr;
                        pwdata_d = req1_wdata;
                        pstrb_d  = req1_write ? req1_strb : {STRB_W{1'b0}};
                    end else begin
                        pwrite_d = req0_write;
                        paddr_d  = req0_addr;
                        pwdata_d = req0_wdata;
                        pstrb_d  = req0_write ? req0_strb : {STRB_W{1'b0}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ST_ACCESS: begin
                if (xfer_done_s) begin
                    state_d   = ST_IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and APB register bank
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            cnt_q        <= cnt_d;
        end
    end

    // Completion is steered to the granted requester in the finishing ACCESS cycle
    always_comb begin
        req0_done = xfer_done_s & ~grant_q;
        req1_done = xfer_done_s & grant_q;
        req0_err  = req0_done & xfer_err_s;
        req1_err  = req1_done & xfer_err_s;
        if (req0_done) begin
            req0_rdata = prdata;
        end else begin
            req0_rdata = '0;
        end
        if (req1_done) begin
            req1_rdata = prdata;
        end else begin
            req1_rdata = '0;
        end
    end

    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign pstrb   = pstrb_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_apb_master_arb.sv
// Directed bench for uart_apb_master_arb with per-requester scoreboards and
// a small APB slave model (programmable wait states, address-selected pslverr).
module tb_uart_apb_master_arb;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic        req0_valid, req0_write, req1_valid, req1_write;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic [3:0]  req0_strb, req1_strb;
    logic        req0_done, req0_err, req1_done, req1_err;
    logic [31:0] req0_rdata, req1_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        busy;

    typedef struct {
        logic        id;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        err;
        int          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic gq[$];

    int          checks = 0;
    int          fails  = 0;
    int          slv_waits = 0;
    int          acc_n = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] rd_key = 32'hC0DE_0000;
    int          rem0 = 0, rem1 = 0, rearm0 = 0, rearm1 = 0;

    // Slave read data is a function of the address so reads are self-describing
    assign prdata = paddr ^ rd_key;

    always #5 pclk = ~pclk;

    uart_apb_master_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_strb(req0_strb), .req0_done(req0_done),
        .req0_err(req0_err), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_strb(req1_strb), .req1_done(req1_done),
        .req1_err(req1_err), .req1_rdata(req1_rdata),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .pslverr(pslverr),
        .prdata(prdata), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic issue(input logic id, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic err, input int lat);
        exp_t e;
        e.id = id; e.wr = wr; e.addr = addr; e.wdata = wdata;
        e.strb = strb; e.err = err; e.lat = lat;
        if (id) begin
            req1_write = wr; req1_addr = addr; req1_wdata = wdata; req1_strb = strb;
            req1_valid = 1'b1;
            q1.push_back(e);
        end else begin
            req0_write = wr; req0_addr = addr; req0_wdata = wdata; req0_strb = strb;
            req0_valid = 1'b1;
            q0.push_back(e);
        end
    endtask

    // Contention re-requests: req0 writes, req1 reads (strobes must be forced to 0)
    task automatic issue_next(input logic id);
        int k;
        if (id) begin
            k = 3 - rem1; rem1--;
            issue(1'b1, 1'b0, 32'h200 + 32'(k * 4), 32'h0, 4'hF, 1'b0, -1);
        end else begin
            k = 3 - rem0; rem0--;
            issue(1'b0, 1'b1, 32'h100 + 32'(k * 4), 32'h1000_0000 + 32'(k), 4'h3, 1'b0, -1);
        end
    endtask

    task automatic run_until(input int n, input int budget, input int cyc0);
        int   seen = 0;
        int   cyc = cyc0;
        logic id;
        logic have;
        exp_t e;
        while (seen < n && cyc < cyc0 + budget) begin
            @(negedge pclk);
            if (rearm0 > 0) begin
                rearm0--;
                if (rearm0 == 0 && rem0 > 0) issue_next(1'b0);
            end
            if (rearm1 > 0) begin
                rearm1--;
                if (rearm1 == 0 && rem1 > 0) issue_next(1'b1);
            end
            if (psel && penable) begin
                pready  = (acc_n >= slv_waits);
                pslverr = pready && (paddr == err_addr);
                acc_n++;
            end else begin
                pready = 1'b0; pslverr = 1'b0; acc_n = 0;
            end
            #1;
            chk("penable_without_psel", {31'd0, penable & ~psel}, 32'd0);
            if (req0_done || req1_done) begin
                chk("done_overlap", {31'd0, req0_done & req1_done}, 32'd0);
                id = req1_done;
                if (gq.size() > 0) chk("grant_order", {31'd0, id}, {31'd0, gq.pop_front()});
                have = id ? (q1.size() > 0) : (q0.size() > 0);
                checks++;
                assert (have) else begin
                    fails++;
                    $error("FAIL unexpected_done observed=req%0d expected=none", id);
                end
                if (have) begin
                    e = id ? q1.pop_front() : q0.pop_front();
                    chk("paddr", paddr, e.addr);
                    chk("pwrite", {31'd0, pwrite}, {31'd0, e.wr});
                    chk("pstrb", {28'd0, pstrb}, e.wr ? {28'd0, e.strb} : 32'd0);
                    chk("err", {31'd0, id ? req1_err : req0_err}, {31'd0, e.err});
                    if (e.wr) chk("pwdata", pwdata, e.wdata);
                    else      chk("rdata", id ? req1_rdata : req0_rdata, e.addr ^ rd_key);
                    if (e.lat >= 0) chk("latency", 32'(cyc), 32'(e.lat));
                end
                if (id) begin req1_valid = 1'b0; rearm1 = 2; end
                else    begin req0_valid = 1'b0; rearm0 = 2; end
                seen++;
            end else begin
                chk("rdata0_idle", req0_rdata, 32'd0);
                chk("rdata1_idle", req1_rdata, 32'd0);
            end
            cyc++;
        end
        checks++;
        assert (seen >= n) else begin
            fails++;
            $error("FAIL done_wait observed=%0d expected=%0d", seen, n);
        end
    endtask

    initial begin
        preset_n = 1'b0;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0; req0_strb = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0; req1_strb = '0;
        pready = 1'b0; pslverr = 1'b0;

        // Contention from reset: both valid, three transfers each
        rem0 = 3; rem1 = 3;
        issue_next(1'b0); issue_next(1'b1);
        gq.push_back(1'b0); gq.push_back(1'b1); gq.push_back(1'b0);
        gq.push_back(1'b1); gq.push_back(1'b0); gq.push_back(1'b1);
        repeat (2) @(negedge pclk);
        #1;
        chk("rst_psel", {31'd0, psel}, 32'd0);
        chk("rst_penable", {31'd0, penable}, 32'd0);
        chk("rst_pwrite", {31'd0, pwrite}, 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_pstrb", {28'd0, pstrb}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {30'd0, req1_done, req0_done}, 32'd0);
        @(negedge pclk);
        preset_n = 1'b1;
        run_until(6, 200, 1);
        repeat (3) @(negedge pclk);

        // Single write, zero wait states
        slv_waits = 0;
        issue(1'b0, 1'b1, 32'h08, 32'hA5, 4'hF, 1'b0, 2);
        @(negedge pclk);
        pready = 1'b0;
        #1;
        chk("setup_psel", {31'd0, psel}, 32'd1);
        chk("setup_penable", {31'd0, penable}, 32'd0);
        chk("setup_busy", {31'd0, busy}, 32'd1);
        run_until(1, 10, 2);

        // Read with three wait states returning 0x5A
        @(negedge pclk);
        slv_waits = 3;
        rd_key = 32'h0000_004A;
        issue(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 5);
        run_until(1, 20, 1);

        // Timeout: slave never answers
        @(negedge pclk);
        slv_waits = 1000;
        issue(1'b0, 1'b1, 32'h20, 32'h1234_5678, 4'h5, 1'b1, 17);
        run_until(1, 40, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            pready = 1'b1;
            #1;
            chk("late_pready_busy", {31'd0, busy}, 32'd0);
            chk("late_pready_done", {30'd0, req1_done, req0_done}, 32'd0);
        end

        // Slave error on req1 write; queued req0 read proceeds normally
        @(negedge pclk);
        pready = 1'b0;
        slv_waits = 0;
        rd_key = 32'hC0DE_0000;
        err_addr = 32'h44;
        issue(1'b1, 1'b1, 32'h44, 32'hCAFE_F00D, 4'hC, 1'b1, -1);
        issue(1'b0, 1'b0, 32'h48, 32'h0, 4'hF, 1'b0, -1);
        gq.push_back(1'b1); gq.push_back(1'b0);
        run_until(2, 40, 1);
        err_addr = 32'hFFFF_FFFF;

        // Reset in ACCESS aborts immediately; afterwards req0 wins the first contest
        @(negedge pclk);
        slv_waits = 1000;
        issue(1'b0, 1'b1, 32'h60, 32'h6060_6060, 4'hF, 1'b0, -1);
        @(negedge pclk);
        pready = 1'b0;
        @(negedge pclk);
        #1;
        chk("abort_pre_penable", {31'd0, penable}, 32'd1);
        preset_n = 1'b0;
        #1;
        chk("abort_psel", {31'd0, psel}, 32'd0);
        chk("abort_penable", {31'd0, penable}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        q0.delete();
        slv_waits = 0;
        issue(1'b0, 1'b1, 32'h64, 32'h6464_6464, 4'h9, 1'b0, -1);
        issue(1'b1, 1'b0, 32'h70, 32'h0, 4'hF, 1'b0, -1);
        gq.push_back(1'b0); gq.push_back(1'b1);
        @(negedge pclk);
        preset_n = 1'b1;
        run_until(2, 40, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
